// File: rtl/concatenator_sched.sv
// Round-robin frame scheduler sharing one concatenator among NUM_REQ requesters.
// Optional stall watchdog with zero padding: define CONCAT_SCHED_WATCHDOG_EN.
module concatenator_sched #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int NUM_WORDS = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [WIDTH-1:0]           o_cat_data,
    output logic                       o_cat_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic                       o_timeout
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WORDS - 1);
    localparam logic [GW-1:0] REQ_LAST = GW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_WORDS < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("concatenator_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BURST = 2'd2
`ifdef CONCAT_SCHED_WATCHDOG_EN
        ,
        S_PAD   = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

`ifdef CONCAT_SCHED_WATCHDOG_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    logic [SW-1:0]     stall_q, stall_d;
    logic              tout_q, tout_d;
`endif

    logic              found;
    logic [GW-1:0]     pick;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    logic [GW-1:0]     next_ptr;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_req_valid[rr_idx(ptr_q, i)]) begin
                found = 1'b1;
                pick  = rr_idx(ptr_q, i);
            end
        end
    end

    assign xfer     = (state_q == S_BURST) && i_req_valid[grant_q];
    assign sel_data = i_req_data[int'(grant_q)*WIDTH +: WIDTH];
    assign next_ptr = (grant_q == REQ_LAST) ? '0 : grant_q + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (state_q == S_BURST) o_req_ready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef CONCAT_SCHED_WATCHDOG_EN
        stall_d = stall_q;
        tout_d  = tout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|i_req_valid) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_BURST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    valid_d = 1'b1;
                    data_d  = sel_data;
`ifdef CONCAT_SCHED_WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        ptr_d   = next_ptr;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef CONCAT_SCHED_WATCHDOG_EN
                else if (stall_q == STALL_LAST) begin
                    stall_d = '0;
                    state_d = S_PAD;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
`ifdef CONCAT_SCHED_WATCHDOG_EN
            // Fill the abandoned frame with zero words so the sink stays aligned.
            S_PAD: begin
                valid_d = 1'b1;
                data_d  = '0;
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = next_ptr;
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef CONCAT_SCHED_WATCHDOG_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tout_q  <= tout_d;
        end
    end
    assign o_timeout = tout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_cat_data   = data_q;
    assign o_cat_valid  = valid_q;
    assign o_grant_id   = grant_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_concatenator_sched.sv
// Scoreboard bench for concatenator_sched: directed frames, reset abort,
// stall behaviour (padding when CONCAT_SCHED_WATCHDOG_EN is defined).
module tb_concatenator_sched;
    localparam int NR = 4;
    localparam int W  = 16;
    localparam int NW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*W-1:0] i_req_data;
    logic [NR-1:0]   i_req_valid;
    logic [NR-1:0]   o_req_ready;
    logic [W-1:0]    o_cat_data;
    logic            o_cat_valid;
    logic [1:0]      o_grant_id;
    logic            o_busy;
    logic            o_frame_done;
    logic            o_timeout;

    always #5 clk = ~clk;

    concatenator_sched #(
        .NUM_REQ(NR), .WIDTH(W), .NUM_WORDS(NW), .TIMEOUT(TO)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_req_data(i_req_data),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .o_cat_data(o_cat_data),
        .o_cat_valid(o_cat_valid),
        .o_grant_id(o_grant_id),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_timeout(o_timeout)
    );

    typedef struct {
        logic [15:0] d;
        logic        done;
        logic [1:0]  g;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   total = 0;
    int   bad = 0;
    bit   en[NR];
    bit   tog[NR];
    bit   hold[NR];
    int   lim[NR];
    int   cnt[NR];
    int   cyc = 0;
    int   n_pop = 0;
    int   frame_start = 0;
    int   last_done = -1;
    int   last_span = -1;
    bit   in_frame = 0;
    bit   gap_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_w(input int k, input int d, input bit done);
        exp_t e;
        e.d = 16'(d);
        e.done = done;
        e.g = 2'(k);
        sb.push_back(e);
    endtask

    task automatic push_frame(input int k, input int first);
        for (int j = 0; j < NW; j++)
            push_w(k, (k << 8) | (first + j), j == NW - 1);
    endtask

    // Requesters: present word {k, cnt[k]} while enabled and below limit.
    initial begin
        i_req_valid = '0;
        i_req_data  = '0;
        for (int k = 0; k < NR; k++) begin
            en[k] = 0; tog[k] = 0; hold[k] = 0; lim[k] = 0; cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                i_req_valid[k] = en[k] && (cnt[k] < lim[k]) && !(tog[k] && hold[k]);
                i_req_data[k*W +: W] = {8'(k), 8'(cnt[k])};
            end
            for (int k = 0; k < NR; k++) begin
                hold[k] = i_req_valid[k] && o_req_ready[k];
                if (hold[k]) cnt[k]++;
            end
        end
    end

    // Monitor: every presented word is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_cat_valid) begin
                if (!in_frame) begin
                    in_frame = 1;
                    frame_start = cyc;
                    if (gap_chk && last_done >= 0)
                        chk("frame_gap", 32'(cyc - last_done), 32'd3);
                end
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", o_cat_data);
                end else begin
                    em = sb.pop_front();
                    chk("cat_data", 32'(o_cat_data), 32'(em.d));
                    chk("frame_done", 32'(o_frame_done), 32'(em.done));
                    chk("grant_id", 32'(o_grant_id), 32'(em.g));
                    n_pop++;
                end
                if (o_frame_done) begin
                    last_span = cyc - frame_start;
                    in_frame = 0;
                    last_done = cyc;
                end
            end else if (o_frame_done) begin
                total++;
                bad++;
                $display("FAIL stray_done: got 1 want 0");
            end
        end
    end

    task automatic drain(input string nm);
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
        chk({nm, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic clear_req();
        for (int k = 0; k < NR; k++) begin
            en[k] = 0; tog[k] = 0; lim[k] = 0; cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        sb.delete();
        clear_req();
        in_frame = 0;
        last_done = -1;
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_cat_valid"}, 32'(o_cat_valid), 32'd0);
        chk({nm, "_cat_data"}, 32'(o_cat_data), 32'd0);
        chk({nm, "_busy"}, 32'(o_busy), 32'd0);
        chk({nm, "_ready"}, 32'(o_req_ready), 32'd0);
        chk({nm, "_grant"}, 32'(o_grant_id), 32'd0);
        chk({nm, "_done"}, 32'(o_frame_done), 32'd0);
        chk({nm, "_timeout"}, 32'(o_timeout), 32'd0);
    endtask

    initial begin
        int viol;
        int base;
        int stall;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle for 1000 cycles.
        viol = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (o_busy || o_req_ready != '0) viol++;
        end
        chk("idle_1000", 32'(viol), 32'd0);

        // Single requester 1.
        push_frame(1, 0);
        lim[1] = 8;
        en[1] = 1;
        drain("single_req1");
        clear_req();

        // All four continuously valid from reset: 0,1,2,3,0.
        do_reset();
        gap_chk = 1;
        push_frame(0, 0);
        push_frame(1, 0);
        push_frame(2, 0);
        push_frame(3, 0);
        push_frame(0, 8);
        lim[0] = 16; lim[1] = 8; lim[2] = 8; lim[3] = 8;
        for (int k = 0; k < NR; k++) en[k] = 1;
        drain("all_rr");
        chk("all_rr_span", 32'(last_span), 32'd7);
        gap_chk = 0;
        clear_req();

        // req2 drops valid for one cycle after each word.
        push_frame(2, 0);
        lim[2] = 8;
        tog[2] = 1;
        en[2] = 1;
        drain("gappy_req2");
        chk("gappy_span", 32'(last_span), 32'd14);
        clear_req();

        // Reset mid-frame, then req0 must win over req3.
        base = n_pop;
        push_frame(1, 0);
        lim[1] = 8;
        en[1] = 1;
        for (int i = 0; i < 200 && n_pop < base + 3; i++) @(posedge clk);
        chk("abort_words", 32'(n_pop - base >= 3), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(posedge clk);
        #2;
        sb.delete();
        clear_req();
        in_frame = 0;
        last_done = -1;
        rst_n = 1'b1;
        push_frame(0, 0);
        push_frame(3, 0);
        lim[0] = 8; lim[3] = 8;
        en[0] = 1; en[3] = 1;
        drain("post_reset");
        clear_req();

        // req0 stalls after three words.
        push_w(0, 16'h0000, 0);
        push_w(0, 16'h0001, 0);
        push_w(0, 16'h0002, 0);
        lim[0] = 3;
        en[0] = 1;
        for (int i = 0; i < 200 && cnt[0] != 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_words", 32'(cnt[0]), 32'd3);
`ifdef CONCAT_SCHED_WATCHDOG_EN
        for (int j = 3; j < NW; j++) push_w(0, 0, j == NW - 1);
        stall = 0;
        while (o_req_ready[0] && stall < 100) begin
            stall++;
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", 32'(stall), 32'(TO));
        drain("pad");
        chk("timeout_set", 32'(o_timeout), 32'd1);
        push_frame(1, 0);
        push_frame(0, 3);
        lim[0] = 11; lim[1] = 8;
        en[1] = 1;
        drain("after_pad");
        chk("timeout_sticky", 32'(o_timeout), 32'd1);
`else
        stall = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (o_req_ready[0]) stall++;
        end
        chk("stall_ready", 32'(stall), 32'd200);
        chk("stall_busy", 32'(o_busy), 32'd1);
        chk("stall_timeout", 32'(o_timeout), 32'd0);
        chk("stall_ready_vec", 32'(o_req_ready), 32'd1);
        chk("stall_drain", 32'(sb.size()), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end
endmodule
